// File: rtl/led_meter_pkg.sv
// Shared types and constants for the LED level meter: FSM states, bar geometry,
// and the level-to-thermometer conversion used to drive the LED pins.
package led_meter_pkg;

   typedef enum logic [1:0] {IDLE, ACQUIRE, UPDATE} state_t;

   localparam int LEVEL_W   = 5;
   localparam int NUM_LEDS  = 16;
   localparam int MAG_SHIFT = 11;

   function automatic logic [NUM_LEDS-1:0] level_to_therm(input logic [LEVEL_W-1:0] level);
      logic [NUM_LEDS-1:0] bar;
      bar = '0;
      for (int i = 0; i < NUM_LEDS; i++)
         bar[i] = (i < int'(level));
      return bar;
   endfunction

endpackage

// File: rtl/led_peak_detect.sv
// Running peak of |sample| over one update window. seed restarts the window,
// optionally primed with the sample arriving in that same cycle.
module led_peak_detect
   import led_meter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        seed,
   input  logic        sample_valid,
   input  logic [15:0] sample_data,
   output logic [14:0] peak
);

   logic [15:0] neg;
   logic [14:0] mag;

   // -32768 has no positive counterpart in 16 bits, so it saturates to 32767
   always_comb begin
      neg = -sample_data;
      if (!sample_data[15])
         mag = sample_data[14:0];
      else if (sample_data == 16'h8000)
         mag = 15'h7FFF;
      else
         mag = neg[14:0];
   end

   always_ff @(posedge clk) begin
      if (rst || clear)
         peak <= '0;
      else if (seed)
         peak <= sample_valid ? mag : '0;
      else if (sample_valid && (mag > peak))
         peak <= mag;
   end

endmodule

// File: rtl/led_meter_ctrl.sv
// 16-LED level meter: windowed peak detection, peak-to-level mapping and
// hold/decay ballistics, all sequenced from a single clock.
module led_meter_ctrl
   import led_meter_pkg::*;
#(
   parameter int TICK_DIV   = 3000000,
   parameter int HOLD_TICKS = 4,
   parameter int DECAY_STEP = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                sample_valid,
   input  logic [15:0]         sample_data,
   output logic [NUM_LEDS-1:0] led,
   output logic [LEVEL_W-1:0]  level,
   output logic                level_valid
);

   localparam int TICK_W = $clog2(TICK_DIV);
   localparam int HOLD_W = $clog2(HOLD_TICKS + 2);
   localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [LEVEL_W-1:0] STEP      = LEVEL_W'(DECAY_STEP);

   state_t              state, state_nxt;
   logic [TICK_W-1:0]   tick_cnt;
   logic [LEVEL_W-1:0]  disp_level, disp_nxt, new_level, decayed;
   logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
   logic [14:0]         peak;
   logic                clear, seed;

   assign clear = (state == IDLE) || ((state == ACQUIRE) && !enable);
   assign seed  = (state == UPDATE);

   led_peak_detect u_peak (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .seed         (seed),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .peak         (peak)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable) state_nxt = ACQUIRE;
         ACQUIRE: if (!enable) state_nxt = IDLE;
                  else if (tick_cnt == TICK_LAST) state_nxt = UPDATE;
         UPDATE:  state_nxt = enable ? ACQUIRE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A fresh maximum restarts the hold; decay never undershoots the new level
   always_comb begin
      new_level = (peak == '0) ? '0 : LEVEL_W'(peak >> MAG_SHIFT) + LEVEL_W'(1);
      decayed   = (disp_level > STEP) ? disp_level - STEP : '0;
      disp_nxt  = disp_level;
      hold_nxt  = hold_cnt;
      if (new_level >= disp_level) begin
         disp_nxt = new_level;
         hold_nxt = HOLD_W'(HOLD_TICKS);
      end else if (hold_cnt != '0) begin
         hold_nxt = hold_cnt - HOLD_W'(1);
      end else begin
         disp_nxt = (new_level > decayed) ? new_level : decayed;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         tick_cnt    <= '0;
         disp_level  <= '0;
         hold_cnt    <= '0;
         led         <= '0;
         level       <= '0;
         level_valid <= 1'b0;
      end else begin
         state       <= state_nxt;
         level_valid <= 1'b0;
         case (state)
            ACQUIRE: begin
               if (enable) begin
                  tick_cnt <= tick_cnt + TICK_W'(1);
               end else begin
                  tick_cnt   <= '0;
                  disp_level <= '0;
                  hold_cnt   <= '0;
                  led        <= '0;
                  level      <= '0;
               end
            end
            UPDATE: begin
               tick_cnt    <= '0;
               disp_level  <= disp_nxt;
               hold_cnt    <= hold_nxt;
               led         <= level_to_therm(disp_nxt);
               level       <= disp_nxt;
               level_valid <= 1'b1;
            end
            default: begin
               tick_cnt   <= '0;
               disp_level <= '0;
               hold_cnt   <= '0;
               led        <= '0;
               level      <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_meter_ctrl.sv
// Directed plus randomized windows for led_meter_ctrl, checked against a
// window-level reference model of peak, level mapping and ballistics.
module tb_led_meter_ctrl;

   localparam int TD    = 8;
   localparam int HOLD  = 2;
   localparam int DECAY = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        sample_valid = 1'b0;
   logic [15:0] sample_data = '0;
   logic [15:0] led;
   logic [4:0]  level;
   logic        level_valid;

   int total = 0;
   int bad   = 0;

   // reference model state
   int mdisp = 0, mhold = 0, wpeak = 0, npeak = 0;
   bit nseed = 0;

   // per-phase stimulus for one window: phases 0..7 acquire, phase 8 is the update cycle
   bit          sv[9];
   logic [15:0] sd[9];

   led_meter_ctrl #(.TICK_DIV(TD), .HOLD_TICKS(HOLD), .DECAY_STEP(DECAY)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .led          (led),
      .level        (level),
      .level_valid  (level_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int magof(input logic [15:0] d);
      int v;
      v = int'($signed(d));
      if (v < 0) v = -v;
      if (v > 32767) v = 32767;
      return v;
   endfunction

   task automatic chk_out(input logic exp_lv, input int exp_lvl);
      logic [31:0] bar;
      bar = (32'd1 << exp_lvl) - 32'd1;
      chk("level_valid", 32'(level_valid), 32'(exp_lv));
      chk("level", 32'(level), 32'(exp_lvl));
      chk("led", 32'(led), bar);
   endtask

   task automatic model_reset();
      mdisp = 0; mhold = 0; wpeak = 0; npeak = 0; nseed = 0;
   endtask

   task automatic model_update();
      int nl, dec;
      nl = (wpeak == 0) ? 0 : (wpeak / 2048) + 1;
      if (nl >= mdisp) begin
         mdisp = nl;
         mhold = HOLD;
      end else if (mhold > 0) begin
         mhold--;
      end else begin
         dec = mdisp - DECAY;
         if (dec < 0) dec = 0;
         mdisp = (nl > dec) ? nl : dec;
      end
      wpeak = nseed ? npeak : 0;
      nseed = 0;
   endtask

   task automatic clr_stim();
      for (int i = 0; i < 9; i++) begin
         sv[i] = 1'b0;
         sd[i] = '0;
      end
   endtask

   // Called at phase 0 of a window (just after an edge); returns at phase 0 of the next.
   task automatic run_win();
      for (int p = 0; p < 9; p++) begin
         if (p > 0) chk("no_strobe", 32'(level_valid), 32'd0);
         sample_valid = sv[p];
         sample_data  = sd[p];
         if (sv[p]) begin
            if (p < 8) begin
               if (magof(sd[p]) > wpeak) wpeak = magof(sd[p]);
            end else begin
               npeak = magof(sd[p]);
               nseed = 1'b1;
            end
         end
         @(posedge clk); #1;
      end
      sample_valid = 1'b0;
      sample_data  = '0;
      model_update();
      chk_out(1'b1, mdisp);
      clr_stim();
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      clr_stim();
      // reset dominates even with enable and samples present
      enable = 1'b1;
      sample_valid = 1'b1;
      sample_data = 16'h7FFF;
      repeat (3) tick();
      chk_out(1'b0, 0);
      rst = 1'b0;
      sample_valid = 1'b0;
      tick();
      chk_out(1'b0, 0);

      // idle windows, no samples
      repeat (2) run_win();

      // full-scale negative: hold for 2 windows then decay to 0
      sv[3] = 1'b1; sd[3] = 16'h8000;
      run_win();
      repeat (18) run_win();

      // +2047 / -2048 -> level 2, then a tiny sample is held off
      sv[1] = 1'b1; sd[1] = 16'd2047;
      sv[5] = 1'b1; sd[5] = 16'hF800;
      run_win();
      sv[2] = 1'b1; sd[2] = 16'd1;
      run_win();

      // sample on the last acquire cycle, seed in the update cycle
      sv[7] = 1'b1; sd[7] = 16'h7FFF;
      sv[8] = 1'b1; sd[8] = 16'h4000;
      run_win();
      repeat (10) begin
         sv[2] = 1'b1; sd[2] = 16'h4000;
         run_win();
      end

      // randomized windows
      repeat (25) begin
         for (int i = 0; i < 9; i++) begin
            sv[i] = ($urandom_range(0, 99) < 30);
            case ($urandom_range(0, 3))
               0: sd[i] = 16'($urandom_range(0, 4095));
               1: sd[i] = 16'($urandom);
               2: sd[i] = 16'h8000;
               default: sd[i] = 16'(-$urandom_range(1, 20000));
            endcase
         end
         if ($urandom_range(0, 3) == 0) clr_stim();
         run_win();
      end

      // enable drop mid-window discards the window
      sv[0] = 1'b1; sd[0] = 16'h7FFF;
      run_win();
      sample_valid = 1'b1; sample_data = 16'h7FFF;
      tick();
      chk("no_strobe", 32'(level_valid), 32'd0);
      sample_valid = 1'b0;
      enable = 1'b0;
      tick();
      chk_out(1'b0, 0);
      repeat (3) begin
         tick();
         chk_out(1'b0, 0);
      end
      model_reset();
      enable = 1'b1;
      tick();
      chk_out(1'b0, 0);
      run_win();

      // one-cycle reset while the bar is full
      sv[4] = 1'b1; sd[4] = 16'h7FFF;
      run_win();
      rst = 1'b1;
      tick();
      chk_out(1'b0, 0);
      rst = 1'b0;
      model_reset();
      tick();
      chk_out(1'b0, 0);
      run_win();
      sv[6] = 1'b1; sd[6] = 16'hC000;
      run_win();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
